// File: rtl/fetch_ctrl_pkg.sv
// Shared cache package: line-transfer command encodings, fetch FSM states
// and index-width helper used by the fetch controller and its interface.
package fetch_ctrl_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_WB   = 2'b00,
    CMD_FILL = 2'b01
  } fetch_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    WB_ADDR,
    WB_DATA,
    FILL_ADDR,
    FILL_DATA,
    DONE
  } fetch_state_e;

  // One extra bit so a beat index can reach list_width without wrapping.
  function automatic int idx_width(input int words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch request, data-array and external-burst signals.
// master = fetch controller view, slave = environment view.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
);
  localparam int TW = $clog2(list_depth);
  localparam int MW = TW + $clog2(list_width);

  logic                  fetch_req;
  logic [CMD_W-1:0]      fetch_cmd;
  logic [TW-1:0]         fetch_tag;
  logic [addr_width-1:0] fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_done;

  logic [MW-1:0]         mem_raddr;
  logic                  mem_ren;
  logic                  mem_rready;
  logic [data_width-1:0] mem_rdata;
  logic                  mem_rdata_valid;

  logic [MW-1:0]         mem_waddr;
  logic                  mem_wen;
  logic [data_width-1:0] mem_wdata;
  logic                  mem_wready;

  logic                  ext_req;
  logic                  ext_we;
  logic [addr_width-1:0] ext_addr;
  logic                  ext_gnt;

  logic [data_width-1:0] ext_wdata;
  logic                  ext_wvalid;
  logic                  ext_wready;

  logic [data_width-1:0] ext_rdata;
  logic                  ext_rdata_valid;
  logic                  ext_rready;

  modport master (
    input  fetch_req, fetch_cmd, fetch_tag, fetch_addr,
    output fetch_gnt, fetch_done,
    output mem_raddr, mem_ren,
    input  mem_rready, mem_rdata, mem_rdata_valid,
    output mem_waddr, mem_wen, mem_wdata,
    input  mem_wready,
    output ext_req, ext_we, ext_addr,
    input  ext_gnt,
    output ext_wdata, ext_wvalid,
    input  ext_wready,
    input  ext_rdata, ext_rdata_valid,
    output ext_rready
  );

  modport slave (
    output fetch_req, fetch_cmd, fetch_tag, fetch_addr,
    input  fetch_gnt, fetch_done,
    input  mem_raddr, mem_ren,
    output mem_rready, mem_rdata, mem_rdata_valid,
    input  mem_waddr, mem_wen, mem_wdata,
    output mem_wready,
    input  ext_req, ext_we, ext_addr,
    output ext_gnt,
    input  ext_wdata, ext_wvalid,
    output ext_wready,
    output ext_rdata, ext_rdata_valid,
    input  ext_rready
  );

endinterface

// File: rtl/line_buf.sv
// Two-entry FIFO staging line beats between the data array and the external
// bus; accepts a push and a pop in the same cycle even when full.
module line_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);
  logic [DW-1:0] store_q [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = store_q[rd_ptr];

  // NOTE: storage is deliberately not reset; count and pointers gate every use of it.
  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Cache line mover: write-back streams a line from the data array to the
// external bus, fill streams an external burst into the data array.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);
  localparam int TW = $clog2(list_depth);
  localparam int LW = $clog2(list_width);
  localparam int IW = idx_width(list_width);
  localparam logic [IW-1:0] BEATS = IW'(list_width);
  localparam logic [IW-1:0] LAST  = IW'(list_width - 1);

  fetch_state_e          state;
  logic [TW-1:0]         tag_q;
  logic [addr_width-1:0] addr_q;
  logic [IW-1:0]         rd_idx;
  logic [IW-1:0]         wr_idx;
  logic [1:0]            rd_out;

  logic                  in_wb;
  logic                  rd_hs;
  logic                  rd_ret;
  logic                  fill_push;
  logic                  buf_push;
  logic                  buf_pop;
  logic [data_width-1:0] buf_head;
  logic [1:0]            buf_count;
  logic [2:0]            inflight;

  line_buf #(.DW(data_width)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (in_wb ? bus.mem_rdata : bus.ext_rdata),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  // NOTE: every output decodes registered state only, so no input reaches an output combinationally.
  assign in_wb    = (state == WB_ADDR) || (state == WB_DATA);
  assign inflight = {1'b0, rd_out} + {1'b0, buf_count};

  assign bus.fetch_gnt  = (state == IDLE);
  assign bus.fetch_done = (state == DONE);

  assign bus.ext_req  = (state == WB_ADDR) || (state == FILL_ADDR);
  assign bus.ext_we   = (state == WB_ADDR);
  assign bus.ext_addr = bus.ext_req ? addr_q : '0;

  assign bus.mem_ren   = in_wb && (rd_idx < BEATS) && (inflight < 3'd2);
  assign bus.mem_raddr = in_wb ? {tag_q, rd_idx[LW-1:0]} : '0;
  assign rd_hs         = bus.mem_ren && bus.mem_rready;
  // Only returns we are actually waiting for may enter the buffer.
  assign rd_ret        = in_wb && bus.mem_rdata_valid && (rd_out != 2'd0);

  assign bus.ext_wvalid = (state == WB_DATA) && (buf_count != 2'd0);
  assign bus.ext_wdata  = bus.ext_wvalid ? buf_head : '0;

  assign bus.ext_rready = (state == FILL_DATA) && (buf_count != 2'd2) && (rd_idx < BEATS);
  assign fill_push      = bus.ext_rready && bus.ext_rdata_valid;

  assign bus.mem_wen   = (state == FILL_DATA) && (buf_count != 2'd0);
  assign bus.mem_waddr = (state == FILL_DATA) ? {tag_q, wr_idx[LW-1:0]} : '0;
  assign bus.mem_wdata = bus.mem_wen ? buf_head : '0;

  assign buf_push = rd_ret || fill_push;
  assign buf_pop  = (bus.ext_wvalid && bus.ext_wready) || (bus.mem_wen && bus.mem_wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tag_q  <= '0;
      addr_q <= '0;
      rd_idx <= '0;
      wr_idx <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.fetch_req) begin
            tag_q  <= bus.fetch_tag;
            addr_q <= bus.fetch_addr;
            case (bus.fetch_cmd)
              CMD_WB:   state <= WB_ADDR;
              CMD_FILL: state <= FILL_ADDR;
              default:  state <= DONE;
            endcase
          end
        end
        WB_ADDR:   if (bus.ext_gnt) state <= WB_DATA;
        FILL_ADDR: if (bus.ext_gnt) state <= FILL_DATA;
        WB_DATA, FILL_DATA: begin
          if (buf_pop && (wr_idx == LAST)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (state == DONE) begin
        rd_idx <= '0;
        wr_idx <= '0;
        rd_out <= '0;
      end else begin
        if (rd_hs || fill_push) rd_idx <= rd_idx + IW'(1);
        if (buf_pop)            wr_idx <= wr_idx + IW'(1);
        case ({rd_hs, rd_ret})
          2'b10:   rd_out <= rd_out + 2'd1;
          2'b01:   rd_out <= rd_out - 2'd1;
          default: rd_out <= rd_out;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected beats, a monitor
// pops and compares them as the DUT presents handshakes.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  fetch_ctrl_if #(.addr_width(32), .list_depth(4), .data_width(32), .list_width(32)) bus ();

  fetch_ctrl #(.addr_width(32), .list_depth(4), .data_width(32), .list_width(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] mem_arr [128];
  int          rd_pend [$];
  int          stall_rd = 0;
  int          stall_wr = 0;
  bit          wr_rand = 1'b0;
  bit          src_active = 1'b0;
  int          src_idx = 0;
  int          src_limit = 32;
  logic [31:0] src_base = '0;
  int          m_out = 0;
  int          m_buf = 0;
  int          max_occ = 0;
  int          done_cnt = 0;

  logic [63:0] exp_addr_q [$];
  logic [63:0] exp_ext_q [$];
  logic [63:0] exp_mem_q [$];
  int          exp_done_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  // Environment: data array, external write sink and external read source.
  initial begin
    bit rd_hs, rdv, wpop;
    for (int i = 0; i < 128; i++) mem_arr[i] = {16'hD00D, 16'(i * 3 + 1)};
    bus.fetch_req = 1'b0; bus.fetch_cmd = '0; bus.fetch_tag = '0; bus.fetch_addr = '0;
    bus.mem_rready = 1'b1; bus.mem_rdata = '0; bus.mem_rdata_valid = 1'b0;
    bus.mem_wready = 1'b1; bus.ext_gnt = 1'b1; bus.ext_wready = 1'b1;
    bus.ext_rdata = '0; bus.ext_rdata_valid = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_rready = (stall_rd > 0) ? 1'b0 : 1'b1;
      if (stall_rd > 0) stall_rd--;
      bus.mem_wready = (stall_wr > 0) ? 1'b0 : 1'b1;
      if (stall_wr > 0) stall_wr--;
      bus.ext_wready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_pend.size() > 0) begin
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata = mem_arr[rd_pend.pop_front()];
      end else begin
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata = '0;
      end
      if (src_active && src_idx < src_limit) begin
        bus.ext_rdata_valid = 1'b1;
        bus.ext_rdata = src_base + 32'(src_idx);
      end else begin
        bus.ext_rdata_valid = 1'b0;
        bus.ext_rdata = '0;
      end
      #1;
      rd_hs = bus.mem_ren && bus.mem_rready;
      rdv   = bus.mem_rdata_valid;
      wpop  = bus.ext_wvalid && bus.ext_wready;
      if (m_out + m_buf > max_occ) max_occ = m_out + m_buf;
      m_out = m_out + int'(rd_hs) - int'(rdv);
      m_buf = m_buf + int'(rdv) - int'(wpop);
      if (rd_hs) rd_pend.push_back(int'(bus.mem_raddr));
      if (bus.ext_rdata_valid && bus.ext_rready) src_idx++;
      if (bus.mem_wen && bus.mem_wready) mem_arr[bus.mem_waddr] = bus.mem_wdata;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.ext_req && bus.ext_gnt) begin
        check("ext_addr_avail", 64'(exp_addr_q.size() != 0), 1);
        if (exp_addr_q.size() != 0) begin
          e = exp_addr_q.pop_front();
          check("ext_addr", 64'({bus.ext_we, bus.ext_addr}), e);
        end
      end
      if (bus.ext_wvalid && bus.ext_wready) begin
        check("wb_beat_avail", 64'(exp_ext_q.size() != 0), 1);
        if (exp_ext_q.size() != 0) begin
          e = exp_ext_q.pop_front();
          check("wb_beat", 64'(bus.ext_wdata), e);
        end
      end
      if (bus.mem_wen && bus.mem_wready) begin
        check("fill_write_avail", 64'(exp_mem_q.size() != 0), 1);
        if (exp_mem_q.size() != 0) begin
          e = exp_mem_q.pop_front();
          check("fill_write", (64'(bus.mem_waddr) << 32) | 64'(bus.mem_wdata), e);
        end
      end
      if (bus.fetch_done) begin
        done_cnt++;
        check("done_expected", 64'(exp_done_q.size() != 0), 1);
        if (exp_done_q.size() != 0) void'(exp_done_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] cmd, input logic [1:0] tag, input logic [31:0] addr);
    int n = 0;
    step();
    bus.fetch_req = 1'b1; bus.fetch_cmd = cmd; bus.fetch_tag = tag; bus.fetch_addr = addr;
    while (!bus.fetch_gnt && n < 50) begin step(); n++; end
    check("req_gnt", 64'(bus.fetch_gnt), 1);
    step();
    bus.fetch_req = 1'b0; bus.fetch_cmd = '0; bus.fetch_tag = '0; bus.fetch_addr = '0;
  endtask

  task automatic expect_wb(input int tag, input logic [31:0] addr);
    exp_addr_q.push_back({31'b0, 1'b1, addr});
    for (int i = 0; i < 32; i++) exp_ext_q.push_back(64'(mem_arr[tag * 32 + i]));
    exp_done_q.push_back(1);
    m_out = 0; m_buf = 0; max_occ = 0;
  endtask

  task automatic expect_fill(input int tag, input logic [31:0] addr, input logic [31:0] base);
    exp_addr_q.push_back({32'b0, addr});
    for (int i = 0; i < 32; i++)
      exp_mem_q.push_back((64'(tag * 32 + i) << 32) | 64'(base + 32'(i)));
    exp_done_q.push_back(1);
    src_base = base; src_idx = 0; src_limit = 36; src_active = 1'b1;
  endtask

  task automatic finish_txn(input string name, input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin step(); n++; end
    check({name, "_done"}, 64'(done_cnt - start), 1);
    repeat (4) step();
    check({name, "_one_done"}, 64'(done_cnt - start), 1);
    check({name, "_left"}, 64'(exp_addr_q.size() + exp_ext_q.size() + exp_mem_q.size()), 0);
    src_active = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_gnt"}, 64'(bus.fetch_gnt), 1);
    check({name, "_ctrl"}, 64'({bus.fetch_done, bus.mem_ren, bus.mem_wen, bus.ext_req,
                               bus.ext_we, bus.ext_wvalid, bus.ext_rready}), 0);
    check({name, "_addr"}, 64'(bus.ext_addr) | 64'(bus.mem_raddr) | 64'(bus.mem_waddr), 0);
    check({name, "_data"}, 64'(bus.ext_wdata) | 64'(bus.mem_wdata), 0);
  endtask

  initial begin
    int n;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_idle("reset");

    // Write-back, tag 2, all ready.
    expect_wb(2, 32'h1000);
    issue(CMD_WB, 2'd2, 32'h1000);
    finish_txn("wb_basic", 400);
    check("wb_basic_occ", 64'(max_occ <= 2), 1);

    // Fill, tag 1, beats 0xA0.., extra beats offered past the burst.
    expect_fill(1, 32'h2000, 32'hA0);
    issue(CMD_FILL, 2'd1, 32'h2000);
    finish_txn("fill_basic", 400);

    // Write-back under random ext_wready and an initial data-array stall.
    wr_rand = 1'b1;
    stall_rd = 3;
    expect_wb(3, 32'h3000);
    issue(CMD_WB, 2'd3, 32'h3000);
    finish_txn("wb_stall", 1000);
    check("wb_stall_occ", 64'(max_occ <= 2), 1);
    wr_rand = 1'b0;

    // Fill with the data-array write port blocked for 10+ cycles.
    stall_wr = 12;
    expect_fill(0, 32'h4000, 32'h100);
    issue(CMD_FILL, 2'd0, 32'h4000);
    repeat (7) step();
    check("fill_stall_rready", 64'(bus.ext_rready), 0);
    check("fill_stall_beats", 64'(src_idx), 2);
    finish_txn("fill_stall", 400);

    // Unsupported command: done the cycle after acceptance, no traffic.
    exp_done_q.push_back(1);
    n = done_cnt;
    issue(2'b11, 2'd1, 32'h7000);
    check("bad_cmd_done", 64'(bus.fetch_done), 1);
    check("bad_cmd_traffic", 64'({bus.ext_req, bus.mem_ren, bus.mem_wen, bus.ext_wvalid, bus.ext_rready}), 0);
    step();
    check("bad_cmd_pulse", 64'({bus.fetch_done, bus.fetch_gnt}), 64'b01);
    check("bad_cmd_count", 64'(done_cnt - n), 1);

    // Reset in the middle of a fill burst.
    expect_fill(2, 32'h5000, 32'h300);
    exp_done_q.delete();
    n = done_cnt;
    issue(CMD_FILL, 2'd2, 32'h5000);
    begin
      int k = 0;
      while (src_idx < 10 && k < 200) begin step(); k++; end
      check("rst_mid_reach", 64'(src_idx >= 10), 1);
    end
    rst = 1'b1;
    src_active = 1'b0;
    exp_addr_q.delete(); exp_mem_q.delete(); exp_ext_q.delete();
    step();
    step();
    rst = 1'b0;
    step();
    check_idle("rst_mid");
    repeat (5) step();
    check("rst_mid_no_done", 64'(done_cnt - n), 0);

    // Recovery: a normal fill after the abort.
    expect_fill(2, 32'h6000, 32'h400);
    issue(CMD_FILL, 2'd2, 32'h6000);
    finish_txn("fill_after_rst", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter addr_width, default 32: byte address width.
REQ-002 SHALL have parameter list_depth, default 4: number of cache lines; TW = $clog2(list_depth).
REQ-003 SHALL have parameter data_width, default 32: beat/word width DW.
REQ-004 SHALL have parameter list_width, default 32: words per line; MW = TW + $clog2(list_width).
REQ-005 SHALL have port clk, in, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, in, 1: reset, synchronous and active-high.
REQ-007 SHALL have port fetch_req, in, 1: line-transfer request from the read/write controllers.
REQ-008 SHALL have port fetch_cmd, in, 2: 00 write-back line, 01 fill line, 1x unsupported.
REQ-009 SHALL have port fetch_tag, in, TW: cache line slot.
REQ-010 SHALL have port fetch_addr, in, addr_width: line-aligned external address.
REQ-011 SHALL have port fetch_gnt, out, 1: request accepted when high with fetch_req.
REQ-012 SHALL have port fetch_done, out, 1: one-cycle completion pulse.
REQ-013 SHALL have ports mem_raddr (out, MW), mem_ren (out, 1), mem_rready (in, 1), mem_rdata (in, DW), mem_rdata_valid (in, 1): data-array read port, data returns at least 1 cycle after the handshake, in order.
REQ-014 SHALL have ports mem_waddr (out, MW), mem_wen (out, 1), mem_wdata (out, DW), mem_wready (in, 1): data-array write port.
REQ-015 SHALL have ports ext_req (out, 1), ext_we (out, 1), ext_addr (out, addr_width), ext_gnt (in, 1): external burst address phase, one burst = list_width beats.
REQ-016 SHALL have ports ext_wdata (out, DW), ext_wvalid (out, 1), ext_wready (in, 1): external write beats.
REQ-017 SHALL have ports ext_rdata (in, DW), ext_rdata_valid (in, 1), ext_rready (out, 1): external read beats; source holds a beat until ext_rready.

Function
REQ-018 SHALL implement FSM states IDLE, WB_ADDR, WB_DATA, FILL_ADDR, FILL_DATA, DONE.
REQ-019 fetch_gnt SHALL equal (state == IDLE); on fetch_req && fetch_gnt, cmd/tag/addr SHALL be latched and the next state SHALL be WB_ADDR (00), FILL_ADDR (01) or DONE (1x, no memory or external traffic).
REQ-020 In *_ADDR, ext_req SHALL be 1, ext_addr = latched addr, ext_we = 1 for write-back, 0 for fill; on ext_gnt the state SHALL advance to WB_DATA or FILL_DATA.
REQ-021 Write-back: mem_ren SHALL assert in WB_ADDR and WB_DATA while read index < list_width and (outstanding reads + buffered words) < 2; mem_raddr = {tag, read index}; read index increments on mem_ren && mem_rready.
REQ-022 Write-back: mem_rdata_valid SHALL push mem_rdata into the 2-entry buffer; ext_wvalid = buffer non-empty, ext_wdata = buffer head; pop on ext_wvalid && ext_wready, in WB_DATA only.
REQ-023 Fill: ext_rready SHALL be high in FILL_DATA while buffer not full; each ext_rdata_valid && ext_rready beat is pushed; mem_wen = buffer non-empty, mem_waddr = {tag, write index}, mem_wdata = head; pop and increment on mem_wen && mem_wready.
REQ-024 Buffer SHALL support simultaneous push and pop in one cycle, including at count 2; count never exceeds 2 and no beat is dropped or duplicated.
REQ-025 The list_width-th beat handshake (ext write for write-back, mem write for fill) SHALL move the state to DONE; indices are $clog2(list_width)+1 bits and never wrap within a burst.
REQ-026 DONE SHALL assert fetch_done for exactly one cycle, then return to IDLE; a new request is accepted no earlier than the cycle after fetch_done.
REQ-027 Extra ext_rdata_valid beats and mem_rdata_valid outside a write-back are ignored.

Reset
REQ-028 On rst: state IDLE, indices, outstanding counter and buffer cleared; fetch_gnt = 1 the following cycle; fetch_done, mem_ren, mem_wen, ext_req, ext_we, ext_wvalid and ext_rready = 0; address/data outputs = 0.
REQ-029 Reset mid-burst SHALL abandon the transfer without a fetch_done pulse.

Structure
REQ-030 fetch_cmd encodings and the FSM state enum SHALL live in the shared cache package.
REQ-031 The 2-entry buffer SHALL be a sub-module line_buf (parameter DW), instantiated once and shared by both directions.

Verification
REQ-032 Write-back, tag 2, addr 0x1000, mem latency 1, all ready high -> ext_addr 0x1000, ext_we 1, 32 beats equal to mem[64..95] in order, one fetch_done.
REQ-033 Fill, tag 1, addr 0x2000, ext beats 0xA0..0xBF -> mem writes to addresses 32..63 with data 0xA0..0xBF, one fetch_done, ext_we 0.
REQ-034 Write-back with ext_wready at 50% random and mem_rready low for 3 cycles -> no loss or duplication, outstanding reads + buffered words <= 2 at all times.
REQ-035 Fill with mem_wready low for 10 cycles -> ext_rready low after 2 buffered beats, all 32 beats written correctly after release.
REQ-036 fetch_cmd 2'b11 accepted at cycle N -> fetch_done at N+1, no ext_req or mem access. Reset asserted at fill beat 10 -> all outputs 0, no fetch_done, fetch_gnt = 1 the cycle after release.
